// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter FSM sharing one resource between N_REQ requesters.
// Optional forced release after MAX_HOLD busy cycles when TIMEOUT_EN is defined.
module rr_arbiter_fsm #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             win_vld,
  output logic [ID_W-1:0]  win_id,
  output logic             timeout
);

  // state   | meaning
  // IDLE    | no owner, arbitrate when any req is high
  // BUSY    | owner holds the resource, gnt = one-hot(owner)
  // GAP     | one-cycle bus turnaround after a release
  // ILLEGAL | unused encoding, recovers to IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    GAP     = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_chk
    $error("rr_arbiter_fsm: illegal parameter combination");
  end

  state_t          state_reg, state_next;
  logic [ID_W-1:0] owner, owner_next;
  logic [ID_W-1:0] ptr, ptr_next;
  logic            to_flag, to_flag_next;

  logic            found;
  logic [ID_W-1:0] cand;
  logic [ID_W:0]   sum;

`ifdef TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_next;
`endif

  // Scan ptr+1, ptr+2, ... modulo N_REQ; sum never exceeds 2*N_REQ-1
  always_comb begin
    found = 1'b0;
    cand  = '0;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      if (!found && req[sum[ID_W-1:0]]) begin
        found = 1'b1;
        cand  = sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner     <= '0;
      ptr       <= ID_W'(N_REQ - 1);
      to_flag   <= 1'b0;
`ifdef TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      to_flag   <= to_flag_next;
`ifdef TIMEOUT_EN
      hold_cnt  <= hold_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner;
    ptr_next     = ptr;
    to_flag_next = to_flag;
`ifdef TIMEOUT_EN
    hold_next    = hold_cnt;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          owner_next = cand;
`ifdef TIMEOUT_EN
          hold_next  = '0;
`endif
        end
      end
      BUSY: begin
        // A normal release wins over a forced one on the same cycle
        if (!req[owner]) begin
          state_next = GAP;
          ptr_next   = owner;
        end
`ifdef TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_next   = GAP;
          ptr_next     = owner;
          to_flag_next = 1'b1;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
`endif
      end
      GAP: begin
        state_next   = IDLE;
        to_flag_next = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        to_flag_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_reg == BUSY) gnt[owner] = 1'b1;
  end

  assign busy    = (state_reg == BUSY);
  assign win_vld = (state_reg == IDLE) && found;
  assign win_id  = win_vld ? cand : '0;

`ifdef TIMEOUT_EN
  assign timeout = (state_reg == GAP) && to_flag;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed self-checking bench for rr_arbiter_fsm; the TIMEOUT_EN section
// runs only when that macro is defined for the build.
module tb_rr_arbiter_fsm;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_fsm #(.N_REQ(N), .ID_W(IW), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .busy    (busy),
    .win_vld (win_vld),
    .win_id  (win_id),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] g, input logic b,
                            input logic wv, input logic [IW-1:0] wi, input logic to);
    check({tag, "_gnt"},     32'(gnt),     32'(g));
    check({tag, "_busy"},    32'(busy),    32'(b));
    check({tag, "_win_vld"}, 32'(win_vld), 32'(wv));
    check({tag, "_win_id"},  32'(win_id),  32'(wi));
    check({tag, "_timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  // One IDLE cycle, hold BUSY cycles (req dropped in the last), one GAP cycle
  task automatic do_grant(input string tag, input int exp_id, input logic [N-1:0] r_idle,
                          input logic [N-1:0] r_busy, input logic [N-1:0] r_drop,
                          input logic [N-1:0] r_gap, input int hold);
    logic [N-1:0] oh;
    oh  = N'(1) << exp_id;
    req = r_idle;
    @(negedge clk);
    check_outs({tag, "_idle"}, '0, 1'b0, 1'b1, IW'(exp_id), 1'b0);
    tick();
    for (int h = 1; h <= hold; h++) begin
      req = (h == hold) ? r_drop : r_busy;
      @(negedge clk);
      check_outs({tag, "_busy"}, oh, 1'b1, 1'b0, '0, 1'b0);
      tick();
    end
    req = r_gap;
    @(negedge clk);
    check_outs({tag, "_gap"}, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
  endtask

  initial begin
    logic [N-1:0] all;
    all   = '1;
    reset = 1'b1;
    req   = '0;
    #2;
    check_outs("rst", '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_outs("idle", '0, 1'b0, 1'b0, '0, 1'b0);
      tick();
    end

    // single request, re-raise by requester 1 during GAP must not show a winner
    do_grant("single", 0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 5);
    @(negedge clk);
    check_outs("single_after", '0, 1'b0, 1'b1, 2'd1, 1'b0);
    req = '0;
    tick();
    @(negedge clk);
    check_outs("single_idle", '0, 1'b0, 1'b0, '0, 1'b0);
    tick();

    reset_pulse();
    for (int g = 0; g < 6; g++) begin
      int e;
      e = g % N;
      do_grant("rot", e, all, all, all & ~(N'(1) << e), all, 2);
    end
    req = '0;
    tick();

    reset_pulse();
    do_grant("skip2", 2, 4'b0100, 4'b1111, 4'b1011, 4'b1011, 2);
    do_grant("skip3", 3, 4'b1011, 4'b1011, 4'b0011, 4'b0111, 1);
    do_grant("skip0", 0, 4'b0111, 4'b0111, 4'b0110, 4'b0110, 1);
    do_grant("skip1", 1, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 1);
    do_grant("skip2b", 2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);

    reset_pulse();
    req = 4'b0100;
    @(negedge clk);
    check_outs("mrst_idle", '0, 1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    @(negedge clk);
    check_outs("mrst_busy", 4'b0100, 1'b1, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b1;
    req   = 4'b0101;
    #1;
    check_outs("mrst_async", '0, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_outs("mrst_rel", '0, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    @(negedge clk);
    check_outs("mrst_gnt", 4'b0001, 1'b1, 1'b0, '0, 1'b0);
    req = '0;
    tick();
    tick();

`ifdef TIMEOUT_EN
    reset_pulse();
    req = 4'b0011;
    for (int p = 0; p < 3; p++) begin
      int e;
      e = p % 2;
      @(negedge clk);
      check_outs("to_idle", '0, 1'b0, 1'b1, IW'(e), 1'b0);
      tick();
      for (int h = 0; h < MH; h++) begin
        @(negedge clk);
        check_outs("to_busy", N'(1) << e, 1'b1, 1'b0, '0, 1'b0);
        tick();
      end
      @(negedge clk);
      check_outs("to_gap", '0, 1'b0, 1'b0, '0, 1'b1);
      tick();
    end
    reset_pulse();
    do_grant("to_norm", 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, MH);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
